// File: rtl/l15_mem_responder.sv
// Memory-side responder for the L1.5 request/response interface.
// Accepts one request at a time, acks it, and answers from a word memory after LATENCY cycles.
module l15_mem_responder #(
    parameter int    ADDR_W    = 12,
    parameter int    LATENCY   = 2,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [3:0]  mem_l15_rqtype,
    input  logic [2:0]  mem_l15_size,
    input  logic [31:0] mem_l15_address,
    input  logic [31:0] mem_l15_data,
    input  logic        mem_l15_val,
    input  logic        mem_l15_req_ack,
    output logic [63:0] l15_mem_data_0,
    output logic [63:0] l15_mem_data_1,
    output logic [3:0]  l15_mem_returntype,
    output logic        l15_mem_val,
    output logic        l15_mem_ack,
    output logic        l15_mem_header_ack,
    output logic [7:0]  err_cnt
);

    // state  | meaning
    // IDLE   | waiting for mem_l15_val
    // ACK    | one-cycle request acknowledge, latency counter loaded
    // WAIT   | counting down the remaining latency
    // RESP   | response valid, held until mem_l15_req_ack
    typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAIT, S_RESP} state_t;

    localparam int         DEPTH  = 1 << ADDR_W;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_rqtype;
    logic [2:0]          r_size;
    logic [ADDR_W+1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [3:0]          r_cnt;
    logic [7:0]          r_err_cnt;
    logic                r_load_ok;
    logic                r_is_load;
    logic [31:0]         r_rd_word;
    logic [31:0]         r_mem [DEPTH];

    logic                w_is_load;
    logic                w_is_store;
    logic                w_misalign;
    logic                w_err;
    logic                w_enter_resp;
    logic                w_wr;
    logic [3:0]          w_be;
    logic [31:0]         w_wdata;
    logic [ADDR_W-1:0]   w_idx;
    logic                w_resp;
    logic                w_unused_addr;

    // High address bits are ignored so the address space wraps at the memory size.
    assign w_unused_addr = ^mem_l15_address[31:ADDR_W+2];

    assign w_idx      = r_addr[ADDR_W+1:2];
    assign w_is_load  = (r_rqtype == 4'b0000) && (r_size <= 3'b010);
    assign w_is_store = (r_rqtype == 4'b0001) && (r_size <= 3'b010);
    assign w_misalign = ((r_size == 3'b001) && r_addr[0]) ||
                        ((r_size == 3'b010) && (r_addr[1:0] != 2'b00));
    assign w_err        = !(w_is_load || w_is_store) || w_misalign;
    assign w_enter_resp = (r_state != S_RESP) && (w_next == S_RESP);
    assign w_wr         = w_enter_resp && w_is_store && !w_misalign;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (mem_l15_val) w_next = S_ACK;
            S_ACK:   w_next = (LATENCY == 1) ? S_RESP : S_WAIT;
            S_WAIT:  if (r_cnt <= 4'd1) w_next = S_RESP;
            S_RESP:  if (mem_l15_req_ack) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = r_wdata;
        case (r_size)
            3'b000: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_wdata[7:0]}};
            end
            3'b001: begin
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_wdata[15:0]}};
            end
            3'b010:  w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state   <= S_IDLE;
            r_rqtype  <= 4'd0;
            r_size    <= 3'd0;
            r_addr    <= '0;
            r_wdata   <= 32'd0;
            r_cnt     <= 4'd0;
            r_err_cnt <= 8'd0;
            r_load_ok <= 1'b0;
            r_is_load <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE) && mem_l15_val) begin
                r_rqtype <= mem_l15_rqtype;
                r_size   <= mem_l15_size;
                r_addr   <= mem_l15_address[ADDR_W+1:0];
                r_wdata  <= mem_l15_data;
            end
            if (r_state == S_ACK) begin
                r_cnt <= LAT_M1;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp) begin
                r_load_ok <= w_is_load && !w_misalign;
                r_is_load <= w_is_load;
                if (w_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    // Memory contents survive reset; only the commit strobe depends on the FSM.
    always_ff @(posedge clk) begin
        if (w_enter_resp) r_rd_word <= r_mem[w_idx];
        for (int i = 0; i < 4; i++) begin
            if (w_wr && w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
    end

    assign w_resp             = (r_state == S_RESP);
    assign l15_mem_val        = w_resp;
    assign l15_mem_ack        = (r_state == S_ACK);
    assign l15_mem_header_ack = (r_state == S_ACK);
    assign l15_mem_data_0     = (w_resp && r_load_ok) ? {r_rd_word, r_rd_word} : 64'd0;
    assign l15_mem_data_1     = 64'd0;
    assign l15_mem_returntype = (w_resp && !r_is_load) ? 4'b0100 : 4'b0000;
    assign err_cnt            = r_err_cnt;

endmodule

// File: tb/tb_l15_mem_responder.sv
// Bench for l15_mem_responder: a LATENCY=2 and a LATENCY=1 instance checked against a byte-level memory model.
module tb_l15_mem_responder;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [3:0]  rqtype = 4'd0;
    logic [2:0]  size = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        val0 = 1'b0, val1 = 1'b0;
    logic        rack0 = 1'b0, rack1 = 1'b0;

    logic [63:0] d0_0, d1_0, d0_1, d1_1;
    logic [3:0]  rt_0, rt_1;
    logic        ov_0, ov_1, ack_0, ack_1, hack_0, hack_1;
    logic [7:0]  err_0, err_1;

    always #5 clk = ~clk;

    l15_mem_responder #(.ADDR_W(12), .LATENCY(2), .INIT_FILE("")) u_dut (
        .clk(clk), .nrst(nrst), .mem_l15_rqtype(rqtype), .mem_l15_size(size),
        .mem_l15_address(addr), .mem_l15_data(wdata), .mem_l15_val(val0),
        .mem_l15_req_ack(rack0), .l15_mem_data_0(d0_0), .l15_mem_data_1(d1_0),
        .l15_mem_returntype(rt_0), .l15_mem_val(ov_0), .l15_mem_ack(ack_0),
        .l15_mem_header_ack(hack_0), .err_cnt(err_0));

    l15_mem_responder #(.ADDR_W(12), .LATENCY(1), .INIT_FILE("")) u_dut1 (
        .clk(clk), .nrst(nrst), .mem_l15_rqtype(rqtype), .mem_l15_size(size),
        .mem_l15_address(addr), .mem_l15_data(wdata), .mem_l15_val(val1),
        .mem_l15_req_ack(rack1), .l15_mem_data_0(d0_1), .l15_mem_data_1(d1_1),
        .l15_mem_returntype(rt_1), .l15_mem_val(ov_1), .l15_mem_ack(ack_1),
        .l15_mem_header_ack(hack_1), .err_cnt(err_1));

    int n_chk = 0;
    int n_err = 0;

    logic        sel = 1'b0;
    logic        txn = 1'b0;
    logic [63:0] exp_data;
    logic [3:0]  exp_rt;
    logic [7:0]  mb [2][16384];
    int          errs [2];

    wire         cur_val  = sel ? ov_1   : ov_0;
    wire         cur_ack  = sel ? ack_1  : ack_0;
    wire         cur_hack = sel ? hack_1 : hack_0;
    wire [63:0]  cur_d0   = sel ? d0_1   : d0_0;
    wire [63:0]  cur_d1   = sel ? d1_1   : d1_0;
    wire [3:0]   cur_rt   = sel ? rt_1   : rt_0;
    wire [7:0]   cur_err  = sel ? err_1  : err_0;
    wire         oth_val  = sel ? ov_0   : ov_1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    // Byte-addressed model; addresses wrap at 16 KiB (4096 words).
    task automatic model_access(input int s, input logic [3:0] rq, input logic [2:0] sz,
                                input logic [31:0] a, input logic [31:0] d);
        int  base, wb;
        bit  misal, known;
        logic [31:0] w;
        base  = int'(a[13:0]);
        wb    = base - (base % 4);
        misal = (sz == 3'd1 && (base % 2) != 0) || (sz == 3'd2 && (base % 4) != 0);
        known = (rq == 4'd0 || rq == 4'd1) && (sz <= 3'd2);
        if (!known || misal) errs[s] = (errs[s] >= 255) ? 255 : errs[s] + 1;
        if (!known) begin
            exp_rt = 4'b0100; exp_data = 64'd0;
        end else if (rq == 4'd0) begin
            exp_rt = 4'b0000;
            w = {mb[s][wb+3], mb[s][wb+2], mb[s][wb+1], mb[s][wb]};
            exp_data = misal ? 64'd0 : {w, w};
        end else begin
            exp_rt = 4'b0100; exp_data = 64'd0;
            if (!misal) for (int k = 0; k < (1 << sz); k++) mb[s][base+k] = d[8*k +: 8];
        end
    endtask

    task automatic set_val(input logic s, input logic v);
        if (s) val1 = v; else val0 = v;
    endtask

    task automatic set_rack(input logic s, input logic v);
        if (s) rack1 = v; else rack0 = v;
    endtask

    task automatic do_req(input logic s, input logic [3:0] rq, input logic [2:0] sz,
                          input logic [31:0] a, input logic [31:0] d, input int hold,
                          input bit hold_val, output logic [63:0] got_d, output logic [3:0] got_rt);
        int  lat, cyc, acks;
        bit  seen;
        lat = s ? 1 : 2;
        model_access(int'(s), rq, sz, a, d);
        @(negedge clk);
        sel = s; txn = 1'b1;
        rqtype = rq; size = sz; addr = a; wdata = d;
        set_val(s, 1'b1);
        @(negedge clk);
        chk("ack_pulse", 64'(cur_ack), 64'd1);
        acks = 1;
        if (!hold_val) set_val(s, 1'b0);
        cyc = 0; seen = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (cur_ack) acks++;
            if (cur_val) begin seen = 1; cyc = i; end
        end
        chk("latency", 64'(cyc), 64'(lat));
        got_d = cur_d0; got_rt = cur_rt;
        if (seen) begin
            set_rack(s, hold == 0);
            for (int h = 1; h <= hold; h++) begin
                @(negedge clk);
                chk("val_held", 64'(cur_val), 64'd1);
                if (cur_ack) acks++;
                if (h == hold) set_rack(s, 1'b1);
            end
            @(negedge clk);
            chk("val_drop", 64'(cur_val), 64'd0);
        end
        set_rack(s, 1'b0);
        set_val(s, 1'b0);
        txn = 1'b0;
        @(negedge clk);
        if (cur_ack) acks++;
        chk("single_ack", 64'(acks), 64'd1);
        chk("err_cnt", 64'(cur_err), 64'(errs[s]));
    endtask

    always @(negedge clk) begin
        if (nrst) begin
            chk("hdr_ack", 64'(cur_hack), 64'(cur_ack));
            chk("other_idle", 64'(oth_val), 64'd0);
            if (txn) begin
                if (cur_val) begin
                    chk("resp_data0", cur_d0, exp_data);
                    chk("resp_data1", cur_d1, 64'd0);
                    chk("resp_rt", 64'(cur_rt), 64'(exp_rt));
                end
            end else begin
                chk("idle_val", 64'(cur_val), 64'd0);
            end
        end
    end

    logic [63:0] gd;
    logic [3:0]  gr;

    initial begin
        errs[0] = 0; errs[1] = 0;
        #12;
        chk("rst_val", 64'(ov_0), 64'd0);
        chk("rst_ack", 64'({ack_0, hack_0, ack_1, hack_1}), 64'd0);
        chk("rst_data", d0_0 | d1_0 | d0_1 | d1_1, 64'd0);
        chk("rst_rt_err", 64'({rt_0, rt_1, err_0, err_1}), 64'd0);
        @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        do_req(1'b0, 4'd1, 3'd2, 32'h100, 32'hDEADBEEF, 2, 0, gd, gr);
        chk("lit_st_rt", 64'(gr), 64'h4);
        do_req(1'b0, 4'd0, 3'd2, 32'h100, 32'h0, 0, 0, gd, gr);
        chk("lit_ld_word", gd, 64'hDEADBEEF_DEADBEEF);
        chk("lit_ld_rt", 64'(gr), 64'h0);

        do_req(1'b0, 4'd1, 3'd0, 32'h101, 32'h000000AA, 0, 0, gd, gr);
        do_req(1'b0, 4'd0, 3'd2, 32'h100, 32'h0, 0, 0, gd, gr);
        chk("lit_byte_st", gd, 64'hDEADAAEF_DEADAAEF);

        do_req(1'b0, 4'd1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 0, gd, gr);
        do_req(1'b0, 4'd1, 3'd1, 32'h102, 32'h00001234, 1, 0, gd, gr);
        do_req(1'b0, 4'd0, 3'd2, 32'h100, 32'h0, 0, 0, gd, gr);
        chk("lit_half_st", gd, 64'h1234BEEF_1234BEEF);

        do_req(1'b0, 4'd1, 3'd1, 32'h103, 32'h00005678, 0, 0, gd, gr);
        chk("lit_mis_st_rt", 64'(gr), 64'h4);
        chk("lit_err1", 64'(err_0), 64'd1);
        do_req(1'b0, 4'd0, 3'd0, 32'h103, 32'h0, 0, 0, gd, gr);
        chk("lit_byte_ld", gd, 64'h1234BEEF_1234BEEF);

        do_req(1'b0, 4'd0, 3'd2, 32'h102, 32'h0, 0, 0, gd, gr);
        chk("lit_mis_ld", gd, 64'd0);
        do_req(1'b0, 4'd3, 3'd2, 32'h100, 32'h0, 0, 0, gd, gr);
        chk("lit_unk_rt", 64'(gr), 64'h4);
        do_req(1'b0, 4'd0, 3'd3, 32'h100, 32'h0, 0, 0, gd, gr);
        chk("lit_err4", 64'(err_0), 64'd4);

        do_req(1'b0, 4'd0, 3'd2, 32'h100, 32'h0, 5, 1, gd, gr);
        chk("lit_bp_data", gd, 64'h1234BEEF_1234BEEF);

        do_req(1'b1, 4'd1, 3'd2, 32'h4000, 32'hCAFEF00D, 0, 0, gd, gr);
        do_req(1'b1, 4'd0, 3'd2, 32'h0000, 32'h0, 1, 0, gd, gr);
        chk("lit_wrap", gd, 64'hCAFEF00D_CAFEF00D);

        // Reset during WAIT of a store: the store must be dropped.
        @(negedge clk);
        sel = 1'b0; txn = 1'b0;
        rqtype = 4'd1; size = 3'd2; addr = 32'h100; wdata = 32'h11111111;
        val0 = 1'b1;
        @(negedge clk);
        chk("mid_ack", 64'(ack_0), 64'd1);
        val0 = 1'b0;
        @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        chk("mid_rst_outs", 64'({ov_0, ack_0, hack_0, rt_0, err_0}), 64'd0);
        chk("mid_rst_data", d0_0 | d1_0, 64'd0);
        @(negedge clk);
        nrst = 1'b1;
        errs[0] = 0; errs[1] = 0;
        repeat (4) @(negedge clk);
        do_req(1'b0, 4'd0, 3'd2, 32'h100, 32'h0, 0, 0, gd, gr);
        chk("lit_rst_drop", gd, 64'h1234BEEF_1234BEEF);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
